// File: rtl/click_square_encoder_if.sv
// Pointer/button inputs and square-select outputs between
// the pin front end and the tic-tac-toe game FSM.
interface click_square_encoder_if;
    logic [9:0] ptr_x;
    logic [9:0] ptr_y;
    logic       btn_click;
    logic       btn_erase;
    logic       btn_restart;
    logic [8:0] cuadro;
    logic       randomClick;
    logic       erase;
    logic       restart;
    logic       busy;

    modport master (
        output ptr_x, ptr_y,
        output btn_click, btn_erase, btn_restart,
        input  cuadro, randomClick,
        input  erase, restart, busy
    );

    modport slave (
        input  ptr_x, ptr_y,
        input  btn_click, btn_erase, btn_restart,
        output cuadro, randomClick,
        output erase, restart, busy
    );
endinterface

// File: rtl/click_square_encoder.sv
// Debounced pointer/button front end: one-hot square select,
// any-click pulse and held erase/restart requests for the game FSM.
module click_square_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 16,
    parameter int BOARD_X0        = 170,
    parameter int BOARD_Y0        = 90,
    parameter int CELL_W          = 100,
    parameter int CELL_H          = 100
) (
    input logic clk_100MHz,
    input logic reset,
    click_square_encoder_if.slave io
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [10:0] X0 = 11'(BOARD_X0);
    localparam logic [10:0] X1 = 11'(BOARD_X0 + CELL_W);
    localparam logic [10:0] X2 = 11'(BOARD_X0 + 2 * CELL_W);
    localparam logic [10:0] X3 = 11'(BOARD_X0 + 3 * CELL_W);
    localparam logic [10:0] Y0 = 11'(BOARD_Y0);
    localparam logic [10:0] Y1 = 11'(BOARD_Y0 + CELL_H);
    localparam logic [10:0] Y2 = 11'(BOARD_Y0 + 2 * CELL_H);
    localparam logic [10:0] Y3 = 11'(BOARD_Y0 + 3 * CELL_H);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

    // bit 0 = click, bit 1 = erase, bit 2 = restart
    logic [2:0]    raw, s1, s2, db, armed, ev;
    logic [1:0]    vld;
    logic [CW-1:0] cnt     [3];
    logic [CW-1:0] arm_cnt [3];

    assign raw = {io.btn_restart, io.btn_erase, io.btn_click};

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            s1  <= '0;
            s2  <= '0;
            vld <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            vld <= {vld[0], 1'b1};
        end
    end

    // A button must be seen released (debounced) after reset before
    // its next rising edge counts, so a button held through reset is ignored.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            db    <= '0;
            armed <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i]     <= '0;
                arm_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] != db[i]) begin
                    if (cnt[i] == DEB_LAST) begin
                        db[i]  <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
                if (!armed[i]) begin
                    if (vld[1] && !s2[i]) begin
                        if (arm_cnt[i] == DEB_LAST) armed[i] <= 1'b1;
                        else arm_cnt[i] <= arm_cnt[i] + CW'(1);
                    end else begin
                        arm_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        ev = '0;
        for (int i = 0; i < 3; i++)
            ev[i] = armed[i] & s2[i] & ~db[i] & (cnt[i] == DEB_LAST);
    end

    logic [10:0] x, y;
    logic [1:0]  col, row;
    logic        col_ok, row_ok;
    logic [3:0]  idx;
    logic [8:0]  sq;

    assign x = {1'b0, io.ptr_x};
    assign y = {1'b0, io.ptr_y};

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b1;
        unique case (1'b1)
            (x >= X0 && x < X1): col = 2'd0;
            (x >= X1 && x < X2): col = 2'd1;
            (x >= X2 && x < X3): col = 2'd2;
            default:             col_ok = 1'b0;
        endcase
        row    = 2'd0;
        row_ok = 1'b1;
        unique case (1'b1)
            (y >= Y0 && y < Y1): row = 2'd0;
            (y >= Y1 && y < Y2): row = 2'd1;
            (y >= Y2 && y < Y3): row = 2'd2;
            default:             row_ok = 1'b0;
        endcase
        idx = {2'b00, row} * 4'd3 + {2'b00, col};
        sq  = (col_ok && row_ok) ? (9'b1 << idx) : 9'b0;
    end

    state_t        state, state_n;
    logic [8:0]    cuadro_q, cuadro_n;
    logic          rc_q, rc_n;
    logic [HW-1:0] ccnt, ccnt_n;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cuadro_q <= '0;
            rc_q     <= 1'b0;
            ccnt     <= '0;
        end else begin
            state    <= state_n;
            cuadro_q <= cuadro_n;
            rc_q     <= rc_n;
            ccnt     <= ccnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cuadro_n = cuadro_q;
        rc_n     = 1'b0;
        ccnt_n   = ccnt;
        unique case (state)
            IDLE: begin
                if (ev[0]) begin
                    state_n  = HOLD;
                    cuadro_n = sq;
                    rc_n     = 1'b1;
                    ccnt_n   = HOLD_LAST;
                end
            end
            HOLD: begin
                if (ccnt == '0) begin
                    cuadro_n = '0;
                    state_n  = WAIT_REL;
                end else begin
                    ccnt_n = ccnt - HW'(1);
                end
            end
            WAIT_REL: begin
                if (!db[0]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    logic [1:0]    hold_on;
    logic [HW-1:0] hcnt [2];

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            hold_on <= '0;
            hcnt[0] <= '0;
            hcnt[1] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (hold_on[j]) begin
                    if (hcnt[j] == '0) hold_on[j] <= 1'b0;
                    else hcnt[j] <= hcnt[j] - HW'(1);
                end else if (ev[j+1]) begin
                    hold_on[j] <= 1'b1;
                    hcnt[j]    <= HOLD_LAST;
                end
            end
        end
    end

    assign io.cuadro      = cuadro_q;
    assign io.randomClick = rc_q;
    assign io.erase       = hold_on[0];
    assign io.restart     = hold_on[1];
    assign io.busy        = (state != IDLE);

endmodule

// File: tb/tb_click_square_encoder.sv
// Bench for click_square_encoder: decode table, corner sequences
// and random stimulus against a timestamp-based reference model.
module tb_click_square_encoder;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    click_square_encoder_if io();

    click_square_encoder #(
        .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .BOARD_X0(170), .BOARD_Y0(90), .CELL_W(100), .CELL_H(100)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .io(io)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: synced stream = raw delayed two samples;
    // debounce via run lengths; channel timing via event timestamps.
    int n = 0;
    int k;
    bit d1 [3], d2 [3], lastv [3], db [3], armed [3];
    int run [3], lowrun [3];
    bit cbusy;
    int cev;
    logic [8:0] csq;
    int hev [3];

    function automatic logic [8:0] ref_sq(int px, int py);
        if (px < 170 || px >= 470 || py < 90 || py >= 390) return 9'd0;
        return 9'd1 << (((py - 90) / 100) * 3 + (px - 170) / 100);
    endfunction

    task automatic model_reset();
        k = 0;
        for (int b = 0; b < 3; b++) begin
            d1[b] = 0; d2[b] = 0; lastv[b] = 0; db[b] = 0;
            armed[b] = 0; run[b] = 0; lowrun[b] = 0;
            hev[b] = -1000;
        end
        cbusy = 0;
        cev = -1000;
        csq = '0;
    endtask

    task automatic model_step(bit [2:0] rawv, int px, int py);
        bit ev [3];
        bit dbp [3];
        bit seen, valid;
        n++;
        k++;
        for (int b = 0; b < 3; b++) begin
            seen  = d2[b];
            valid = (k >= 3);
            d2[b] = d1[b];
            d1[b] = rawv[b];
            run[b] = (seen == lastv[b]) ? run[b] + 1 : 1;
            lastv[b] = seen;
            lowrun[b] = (valid && !seen) ? lowrun[b] + 1 : 0;
            dbp[b] = db[b];
            ev[b] = 0;
            if (seen != db[b] && run[b] >= DEB) begin
                db[b] = seen;
                ev[b] = seen && armed[b];
            end
            if (lowrun[b] >= DEB) armed[b] = 1;
        end
        if (cbusy && n >= cev + HOLD + 1 && !dbp[0]) begin
            cbusy = 0;
        end else if (!cbusy && ev[0]) begin
            cbusy = 1;
            cev = n;
            csq = ref_sq(px, py);
        end
        for (int c = 1; c < 3; c++)
            if (ev[c] && n > hev[c] + HOLD) hev[c] = n;
    endtask

    int print_budget = 30;

    task automatic check_outputs();
        logic [8:0] e_cq;
        logic e_rc, e_er, e_rs, e_bz;
        e_cq = (cbusy && n < cev + HOLD) ? csq : 9'd0;
        e_rc = cbusy && (n == cev);
        e_bz = cbusy;
        e_er = (n >= hev[1]) && (n < hev[1] + HOLD);
        e_rs = (n >= hev[2]) && (n < hev[2] + HOLD);
        tests++;
        if (io.cuadro !== e_cq || io.randomClick !== e_rc || io.busy !== e_bz
            || io.erase !== e_er || io.restart !== e_rs) begin
            fails++;
            if (print_budget > 0) begin
                print_budget--;
                $display("FAIL cycle %0d: got cq=%b rc=%b bz=%b er=%b rs=%b expected cq=%b rc=%b bz=%b er=%b rs=%b",
                         n, io.cuadro, io.randomClick, io.busy, io.erase, io.restart,
                         e_cq, e_rc, e_bz, e_er, e_rs);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        if (!reset) model_reset();
        else model_step({io.btn_restart, io.btn_erase, io.btn_click},
                        int'(io.ptr_x), int'(io.ptr_y));
        @(negedge clk_100MHz);
        check_outputs();
    endtask

    int cyc = 0;
    int rc_cnt, cq_cnt, er_cnt, rs_cnt, both_cnt, align_bad, rc_t, cq_t;
    logic [8:0] rc_sq;

    task automatic clr();
        rc_cnt = 0; cq_cnt = 0; er_cnt = 0; rs_cnt = 0;
        both_cnt = 0; align_bad = 0; rc_t = -1; cq_t = -1; rc_sq = '0;
    endtask

    task automatic run_cyc(int c);
        for (int i = 0; i < c; i++) begin
            tick();
            cyc++;
            if (io.randomClick) begin
                rc_cnt++;
                rc_sq = io.cuadro;
                rc_t = cyc;
            end
            if (io.cuadro != 0) begin
                if (cq_cnt == 0) cq_t = cyc;
                cq_cnt++;
            end
            er_cnt += int'(io.erase);
            rs_cnt += int'(io.restart);
            if (io.erase && io.cuadro[8]) both_cnt++;
            if (io.erase != (io.cuadro != 0)) align_bad++;
        end
    endtask

    typedef struct {
        int x;
        int y;
        logic [8:0] exp_sq;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{275,  95, 9'b000000010};
        vecs[1]  = '{270, 190, 9'b000010000};
        vecs[2]  = '{469, 389, 9'b100000000};
        vecs[3]  = '{169, 200, 9'b000000000};
        vecs[4]  = '{470, 200, 9'b000000000};
        vecs[5]  = '{380, 290, 9'b100000000};
        vecs[6]  = '{170,  90, 9'b000000001};
        vecs[7]  = '{269, 189, 9'b000000001};
        vecs[8]  = '{170, 389, 9'b001000000};
        vecs[9]  = '{469,  90, 9'b000000100};
        vecs[10] = '{200,  89, 9'b000000000};
        vecs[11] = '{200, 390, 9'b000000000};

        io.ptr_x = '0; io.ptr_y = '0;
        io.btn_click = 0; io.btn_erase = 0; io.btn_restart = 0;
        model_reset();

        clr();
        run_cyc(3);
        chk("reset_cuadro", int'(io.cuadro), 0);
        chk("reset_busy", int'(io.busy), 0);
        chk("reset_erase_restart", int'({io.erase, io.restart}), 0);
        reset = 1'b1;
        run_cyc(10);

        foreach (vecs[i]) begin
            clr();
            io.ptr_x = 10'(vecs[i].x);
            io.ptr_y = 10'(vecs[i].y);
            io.btn_click = 1;
            run_cyc(8);
            io.ptr_x = 10'($urandom_range(0, 1023));
            io.ptr_y = 10'($urandom_range(0, 1023));
            run_cyc(3);
            io.btn_click = 0;
            run_cyc(30);
            chk($sformatf("vec%0d_pulses", i), rc_cnt, 1);
            chk($sformatf("vec%0d_square", i), int'(rc_sq), int'(vecs[i].exp_sq));
            chk($sformatf("vec%0d_hold", i), cq_cnt, (vecs[i].exp_sq != 0) ? HOLD : 0);
            chk($sformatf("vec%0d_align", i), cq_t, (vecs[i].exp_sq != 0) ? rc_t : -1);
            chk($sformatf("vec%0d_idle", i), int'(io.busy), 0);
        end

        clr();
        io.ptr_x = 10'd275; io.ptr_y = 10'd95;
        for (int i = 0; i < 10; i++) begin
            io.btn_click = ~io.btn_click;
            run_cyc(2);
        end
        io.btn_click = 0;
        run_cyc(10);
        chk("bounce_pulses", rc_cnt, 0);
        chk("bounce_cuadro", cq_cnt, 0);

        clr();
        io.btn_click = 1;
        run_cyc(100);
        chk("held_busy", int'(io.busy), 1);
        io.btn_click = 0;
        run_cyc(10);
        chk("held_pulses", rc_cnt, 1);
        chk("held_released", int'(io.busy), 0);

        clr();
        io.btn_click = 1; run_cyc(7);
        io.btn_click = 0; run_cyc(6);
        io.btn_click = 1; run_cyc(6);
        io.btn_click = 0; run_cyc(15);
        chk("reclick_in_hold", rc_cnt, 1);
        io.btn_click = 1; run_cyc(10);
        io.btn_click = 0; run_cyc(30);
        chk("reclick_after_release", rc_cnt, 2);

        clr();
        io.ptr_x = 10'd380; io.ptr_y = 10'd290;
        io.btn_click = 1; io.btn_erase = 1;
        run_cyc(8);
        io.btn_click = 0; io.btn_erase = 0;
        run_cyc(30);
        chk("simul_erase_len", er_cnt, HOLD);
        chk("simul_overlap", both_cnt, HOLD);
        chk("simul_misalign", align_bad, 0);

        clr();
        io.btn_restart = 1; run_cyc(8);
        io.btn_restart = 0; run_cyc(6);
        io.btn_restart = 1; run_cyc(8);
        io.btn_restart = 0; run_cyc(30);
        chk("restart_no_retrigger", rs_cnt, HOLD);

        clr();
        io.ptr_x = 10'd275; io.ptr_y = 10'd95;
        io.btn_click = 1; io.btn_erase = 1; io.btn_restart = 1;
        run_cyc(10);
        chk("midhold_cuadro_cycles", cq_cnt, 5);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("midhold_cuadro", int'(io.cuadro), 0);
        chk("midhold_busy", int'(io.busy), 0);
        chk("midhold_erase_restart", int'({io.erase, io.restart}), 0);
        run_cyc(3);
        reset = 1'b1;
        clr();
        run_cyc(30);
        chk("after_reset_held_click", rc_cnt, 0);
        chk("after_reset_held_er_rs", er_cnt + rs_cnt, 0);
        io.btn_click = 0; io.btn_erase = 0; io.btn_restart = 0;
        run_cyc(15);
        io.btn_click = 1; run_cyc(10);
        io.btn_click = 0; run_cyc(25);
        chk("after_reset_new_press", rc_cnt, 1);

        for (int e = 0; e < 150; e++) begin
            io.btn_click   = 1'($urandom_range(0, 1));
            io.btn_erase   = 1'($urandom_range(0, 1));
            io.btn_restart = 1'($urandom_range(0, 1));
            io.ptr_x = 10'($urandom_range(140, 500));
            io.ptr_y = 10'($urandom_range(60, 420));
            run_cyc($urandom_range(1, 25));
        end
        io.btn_click = 0; io.btn_erase = 0; io.btn_restart = 0;
        run_cyc(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
